// File: rtl/neogeo_wb_sdram_slave_if.sv
// Bus bundles for the NeoGeo Wishbone-to-SDRAM responder.
// neogeo_wb_if carries the 32-bit Wishbone classic bus.
// neogeo_mem_if carries the 16-bit req/ack port of the SDRAM controller.

interface neogeo_wb_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

interface neogeo_mem_if #(
    parameter int ADDR_W = 26
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/neogeo_wb_sdram_slave.sv
// Wishbone classic responder that splits each 32-bit access into up to two
// 16-bit req/ack transactions (low halfword first), skipping halfwords whose
// byte selects are all zero. A per-halfword wait limit turns a stuck memory
// into a wb_err_o pulse; dropping wb_cyc_i abandons the access silently once
// the outstanding halfword has finished.

module neogeo_wb_sdram_slave #(
    parameter int ADDR_W  = 26,
    parameter int TIMEOUT = 255
) (
    input  logic         wb_clk_i,
    input  logic         reset_n,
    neogeo_wb_if.slave   wb,
    neogeo_mem_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_GAP,
        S_HI,
        S_RESP
    } state_t;

    // Counter value in the last allowed wait cycle of a halfword.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    // Registered state and outputs.
    state_t            r_state;
    logic [ADDR_W-3:0] r_word;
    logic              r_we;
    logic [1:0]        r_sel_hi;
    logic [15:0]       r_dat_hi;
    logic [31:0]       r_buf;
    logic [15:0]       r_cnt;
    logic              r_abort;
    logic              r_wb_ack;
    logic              r_wb_err;
    logic [31:0]       r_wb_dat;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-2:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic [1:0]        r_mem_be;

    // Next-state values.
    state_t            w_state_nxt;
    logic [ADDR_W-3:0] w_word_nxt;
    logic              w_we_nxt;
    logic [1:0]        w_sel_hi_nxt;
    logic [15:0]       w_dat_hi_nxt;
    logic [31:0]       w_buf_nxt;
    logic [15:0]       w_cnt_nxt;
    logic              w_abort_nxt;
    logic              w_wb_ack_nxt;
    logic              w_wb_err_nxt;
    logic [31:0]       w_wb_dat_nxt;
    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-2:0] w_mem_addr_nxt;
    logic [15:0]       w_mem_wdata_nxt;
    logic [1:0]        w_mem_be_nxt;
    logic              w_timeout;

    // Address bits outside the halfword-address field are deliberately ignored.
    logic w_unused_adr;
    assign w_unused_adr = ^{wb.wb_adr_i[31:ADDR_W], wb.wb_adr_i[1:0]};

    assign wb.wb_ack_o   = r_wb_ack;
    assign wb.wb_err_o   = r_wb_err;
    assign wb.wb_dat_o   = r_wb_dat;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_be    = r_mem_be;

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that every port is driven straight from a flop.
    always_comb begin
        // NOTE: every variable gets its default here, before any branch, so no path can leave one unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_word_nxt      = r_word;
        w_we_nxt        = r_we;
        w_sel_hi_nxt    = r_sel_hi;
        w_dat_hi_nxt    = r_dat_hi;
        w_buf_nxt       = r_buf;
        w_cnt_nxt       = r_cnt;
        w_abort_nxt     = r_abort;
        w_wb_ack_nxt    = 1'b0;
        w_wb_err_nxt    = 1'b0;
        w_wb_dat_nxt    = '0;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_timeout       = (r_cnt == CNT_LAST);

        unique case (r_state)
            S_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    w_word_nxt   = wb.wb_adr_i[ADDR_W-1:2];
                    w_we_nxt     = wb.wb_we_i;
                    w_sel_hi_nxt = wb.wb_sel_i[3:2];
                    w_dat_hi_nxt = wb.wb_dat_i[31:16];
                    w_buf_nxt    = '0;
                    w_abort_nxt  = 1'b0;
                    w_cnt_nxt    = '0;
                    w_mem_we_nxt = wb.wb_we_i;
                    if (|wb.wb_sel_i[1:0]) begin
                        w_state_nxt     = S_LO;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = {wb.wb_adr_i[ADDR_W-1:2], 1'b0};
                        w_mem_be_nxt    = wb.wb_sel_i[1:0];
                        w_mem_wdata_nxt = wb.wb_dat_i[15:0];
                    end else if (|wb.wb_sel_i[3:2]) begin
                        w_state_nxt     = S_HI;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = {wb.wb_adr_i[ADDR_W-1:2], 1'b1};
                        w_mem_be_nxt    = wb.wb_sel_i[3:2];
                        w_mem_wdata_nxt = wb.wb_dat_i[31:16];
                    end else begin
                        // Nothing selected: answer at once with zero data.
                        w_state_nxt  = S_RESP;
                        w_wb_ack_nxt = 1'b1;
                    end
                end
            end

            S_LO, S_HI: begin
                // An abort is remembered but the halfword in flight still runs to completion.
                w_abort_nxt = r_abort | ~wb.wb_cyc_i;
                if (mem.mem_ack || w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    if (mem.mem_ack && !r_we) begin
                        if (r_state == S_LO) begin
                            w_buf_nxt[15:0] = mem.mem_rdata;
                        end else begin
                            w_buf_nxt[31:16] = mem.mem_rdata;
                        end
                    end
                    if (w_abort_nxt) begin
                        w_state_nxt = S_IDLE;
                    end else if (!mem.mem_ack) begin
                        // Timed out: skip any remaining halfword and terminate with an error.
                        w_state_nxt  = S_RESP;
                        w_wb_err_nxt = 1'b1;
                        w_wb_dat_nxt = w_buf_nxt;
                    end else if ((r_state == S_LO) && (|r_sel_hi)) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt  = S_RESP;
                        w_wb_ack_nxt = 1'b1;
                        w_wb_dat_nxt = w_buf_nxt;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            S_GAP: begin
                if (r_abort || !wb.wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt     = S_HI;
                    w_cnt_nxt       = '0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_addr_nxt  = {r_word, 1'b1};
                    w_mem_be_nxt    = r_sel_hi;
                    w_mem_wdata_nxt = r_dat_hi;
                end
            end

            S_RESP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and output flops; reset abandons any access in flight.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_sel_hi    <= '0;
            r_dat_hi    <= '0;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_abort     <= 1'b0;
            r_wb_ack    <= 1'b0;
            r_wb_err    <= 1'b0;
            r_wb_dat    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_word      <= w_word_nxt;
            r_we        <= w_we_nxt;
            r_sel_hi    <= w_sel_hi_nxt;
            r_dat_hi    <= w_dat_hi_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_abort     <= w_abort_nxt;
            r_wb_ack    <= w_wb_ack_nxt;
            r_wb_err    <= w_wb_err_nxt;
            r_wb_dat    <= w_wb_dat_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
        end
    end

endmodule

// File: tb/tb_neogeo_wb_sdram_slave.sv
// Scoreboard bench for neogeo_wb_sdram_slave. Each access pushes its expected
// memory transactions and Wishbone response; a memory responder and a
// Wishbone monitor pop and compare as the DUT presents them.

module tb_neogeo_wb_sdram_slave;
    localparam int ADDR_W  = 26;
    localparam int TIMEOUT = 4;
    localparam int NEVER   = 1000;

    typedef struct {
        logic [24:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          wait_cycles;
    } txn_t;

    typedef enum {R_ACK, R_ERR} rkind_t;

    typedef struct {
        rkind_t      kind;
        logic        check_dat;
        logic [31:0] dat;
        longint      cycle;
    } resp_t;

    logic clk = 1'b0;
    logic reset_n;

    neogeo_wb_if wb();
    neogeo_mem_if #(.ADDR_W(ADDR_W)) mem();

    neogeo_wb_sdram_slave #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (clk),
        .reset_n  (reset_n),
        .wb       (wb),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     resp_seen = 0;
    longint cyc_cnt = 0;

    txn_t        exp_txn_q[$];
    resp_t       resp_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] sdram[int];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 40503) ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] sdram_rd(input int a);
        return sdram.exists(a) ? sdram[a] : init_val(a);
    endfunction

    function automatic void ref_write(input int a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] v;
        v = ref_rd(a);
        if (be[0]) v[7:0] = d[7:0];
        if (be[1]) v[15:8] = d[15:8];
        ref_mem[a] = v;
    endfunction

    // Reference model: decides which halfwords happen, what they carry, how
    // long the access takes and what the master should see at the end.
    task automatic plan(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input int wl, input int wh, input bit abort,
                        input longint raise_cnt);
        logic [23:0] word;
        logic [24:0] a_lo;
        logic [24:0] a_hi;
        bit          lo;
        bit          hi;
        bit          err;
        int          lat;
        logic [31:0] rd;
        word = adr[25:2];
        a_lo = {word, 1'b0};
        a_hi = {word, 1'b1};
        lo   = |sel[1:0];
        hi   = |sel[3:2];
        err  = 0;
        lat  = 0;
        rd   = '0;
        if (lo) begin
            exp_txn_q.push_back('{addr: a_lo, we: we, be: sel[1:0], wdata: dat[15:0], wait_cycles: wl});
            if (wl >= TIMEOUT) begin
                err = 1;
                lat += TIMEOUT;
            end else begin
                lat += wl + 1;
                if (we) ref_write(int'(a_lo), sel[1:0], dat[15:0]);
                else rd[15:0] = ref_rd(int'(a_lo));
            end
        end
        if (hi && !err && !(abort && lo)) begin
            if (lo) lat += 1;
            exp_txn_q.push_back('{addr: a_hi, we: we, be: sel[3:2], wdata: dat[31:16], wait_cycles: wh});
            if (wh >= TIMEOUT) begin
                err = 1;
                lat += TIMEOUT;
            end else begin
                lat += wh + 1;
                if (we) ref_write(int'(a_hi), sel[3:2], dat[31:16]);
                else rd[31:16] = ref_rd(int'(a_hi));
            end
        end
        lat += 1;
        if (!abort) begin
            resp_q.push_back('{kind: err ? R_ERR : R_ACK, check_dat: !err && !we, dat: rd,
                               cycle: raise_cnt + longint'(lat)});
        end
    endtask

    task automatic do_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, input int wl, input int wh, input bit abort);
        int seen0;
        int n;
        @(posedge clk);
        #1;
        plan(adr, dat, sel, we, wl, wh, abort, cyc_cnt);
        seen0 = resp_seen;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_we_i  = we;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        if (abort) begin
            // Request edge, then drop the cycle while the low halfword is pending.
            @(posedge clk);
            #1;
            wb.wb_cyc_i = 1'b0;
            wb.wb_stb_i = 1'b0;
            repeat (TIMEOUT + 8) @(posedge clk);
            @(negedge clk);
            check("abort_no_resp", 64'(resp_seen - seen0), 0);
            check("abort_req_low", mem.mem_req, 0);
        end else begin
            n = 0;
            while (resp_seen == seen0 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("resp_arrived", resp_seen != seen0, 1);
            @(posedge clk);
            #1;
            wb.wb_cyc_i = 1'b0;
            wb.wb_stb_i = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wb_ack_o"}, wb.wb_ack_o, 0);
        check({tag, "_wb_err_o"}, wb.wb_err_o, 0);
        check({tag, "_wb_dat_o"}, wb.wb_dat_o, 0);
        check({tag, "_mem_req"}, mem.mem_req, 0);
        check({tag, "_mem_we"}, mem.mem_we, 0);
        check({tag, "_mem_addr"}, mem.mem_addr, 0);
        check({tag, "_mem_wdata"}, mem.mem_wdata, 0);
        check({tag, "_mem_be"}, mem.mem_be, 0);
    endtask

    // SDRAM port model: checks each request against the expected queue,
    // holds it for the planned wait, checks stability and request length.
    initial begin : responder
        txn_t        cur;
        bit          in_acc;
        int          left;
        int          len;
        logic [24:0] s_addr;
        logic        s_we;
        logic [1:0]  s_be;
        logic [15:0] s_wdata;
        logic [15:0] v;
        int          exp_len;
        in_acc = 0;
        left = 0;
        len = 0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem.mem_ack = 1'b0;
            if (!reset_n) begin
                in_acc = 0;
            end else if (mem.mem_req) begin
                if (!in_acc) begin
                    in_acc = 1;
                    len = 0;
                    s_addr = mem.mem_addr;
                    s_we = mem.mem_we;
                    s_be = mem.mem_be;
                    s_wdata = mem.mem_wdata;
                    check("mem_txn_expected", 64'(exp_txn_q.size() != 0), 1);
                    if (exp_txn_q.size() != 0) begin
                        cur = exp_txn_q.pop_front();
                        check("mem_addr", mem.mem_addr, cur.addr);
                        check("mem_we", mem.mem_we, cur.we);
                        check("mem_be", mem.mem_be, cur.be);
                        if (cur.we) check("mem_wdata", mem.mem_wdata, cur.wdata);
                    end else begin
                        cur = '{addr: s_addr, we: s_we, be: s_be, wdata: s_wdata, wait_cycles: 0};
                    end
                    left = cur.wait_cycles;
                end else begin
                    check("mem_stable", {mem.mem_addr, mem.mem_we, mem.mem_be, mem.mem_wdata},
                          {s_addr, s_we, s_be, s_wdata});
                end
                len++;
                if (left == 0) begin
                    mem.mem_ack = 1'b1;
                    if (mem.mem_we) begin
                        v = sdram_rd(int'(mem.mem_addr));
                        if (mem.mem_be[0]) v[7:0] = mem.mem_wdata[7:0];
                        if (mem.mem_be[1]) v[15:8] = mem.mem_wdata[15:8];
                        sdram[int'(mem.mem_addr)] = v;
                    end else begin
                        mem.mem_rdata = sdram_rd(int'(mem.mem_addr));
                    end
                end else begin
                    left--;
                end
            end else begin
                if (in_acc) begin
                    exp_len = (cur.wait_cycles + 1 < TIMEOUT) ? cur.wait_cycles + 1 : TIMEOUT;
                    check("mem_req_len", 64'(len), 64'(exp_len));
                    in_acc = 0;
                end
                // Stray acknowledges while no request is up must be ignored.
                if ($urandom_range(0, 3) == 0) begin
                    mem.mem_ack = 1'b1;
                    mem.mem_rdata = 16'($urandom());
                end
            end
        end
    end

    // Wishbone monitor: every ack/err pulse is matched against the scoreboard.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (wb.wb_ack_o || wb.wb_err_o)) begin
                check("wb_resp_expected", 64'(resp_q.size() != 0), 1);
                if (resp_q.size() != 0) begin
                    e = resp_q.pop_front();
                    check("wb_ack_o", wb.wb_ack_o, e.kind == R_ACK);
                    check("wb_err_o", wb.wb_err_o, e.kind == R_ERR);
                    check("resp_cycle", cyc_cnt, e.cycle);
                    if (e.check_dat) check("wb_dat_o", wb.wb_dat_o, e.dat);
                end
                resp_seen++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          wl;
        int          wh;
        reset_n = 1'b0;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = '0;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Full 32-bit write, zero-wait memory.
        do_access(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 0, 0);

        // High-halfword read with three wait cycles.
        sdram[5] = 16'h1234;
        ref_mem[5] = 16'h1234;
        do_access(32'h0000_0008, 32'h0, 4'hC, 1'b0, 0, 3, 0);

        // Nothing selected: immediate ack, no memory traffic.
        do_access(32'h0000_0040, 32'h5555_AAAA, 4'h0, 1'b0, 0, 0, 0);

        // Memory never answers the low halfword.
        do_access(32'h0000_0020, 32'h0, 4'hF, 1'b0, NEVER, 0, 0);

        // Cycle dropped during the low halfword of a write, then read back.
        do_access(32'h0000_0200, 32'hCAFE_F00D, 4'hF, 1'b1, 2, 0, 1);
        do_access(32'h0000_0200, 32'h0, 4'hF, 1'b0, 1, 1, 0);

        // Reset pulsed while the high halfword is outstanding.
        @(posedge clk);
        #1;
        plan(32'h0000_0044, 32'h0, 4'hF, 1'b0, 0, 2, 0, cyc_cnt);
        wb.wb_adr_i = 32'h0000_0044;
        wb.wb_sel_i = 4'hF;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        resp_q.delete();
        exp_txn_q.delete();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        do_access(32'h0000_0044, 32'h0, 4'hF, 1'b0, 1, 0, 0);

        // Randomized accesses over a small address window.
        for (int i = 0; i < 80; i++) begin
            adr = $urandom();
            adr[25:2] = 24'($urandom_range(0, 15));
            dat = $urandom();
            sel = 4'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            wl  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
            wh  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
            do_access(adr, dat, sel, we, wl, wh, 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        check("txn_queue_empty", 64'(exp_txn_q.size()), 0);
        check("resp_queue_empty", 64'(resp_q.size()), 0);
        for (int a = 0; a < 32; a++) begin
            check("sdram_contents", sdram_rd(a), ref_rd(a));
        end
        check("sdram_0x80", sdram_rd(32'h80), ref_rd(32'h80));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neogeo_wb_sdram_slave.md
# neogeo_wb_sdram_slave

Wishbone classic-cycle responder that terminates the 32-bit bus driven by the NeoGeo SDRAM request bridge and turns each access into one or two 16-bit transactions on a req/ack memory port. It sits between the Wishbone interconnect and the SDRAM controller's 16-bit port. It handles byte selects, skips unused halfwords, assembles read data and reports timeouts with `wb_err_o`.

## Interface
- `ADDR_W`, 26: Wishbone byte-address bits used; upper `wb_adr_i` bits are ignored.
- `TIMEOUT`, 255: cycles to wait for `mem_ack` per halfword before erroring; range 1..65535.
- `wb_clk_i` in 1: single clock for all logic.
- `reset_n` in 1: reset is asynchronous and active-low.
- `wb_adr_i` in 32: byte address; bits [1:0] ignored.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte lanes; [1:0] = low halfword, [3:2] = high halfword.
- `wb_we_i` in 1: 1 = write.
- `wb_stb_i`, `wb_cyc_i` in 1: request when both high.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o` out 1: one-cycle completion pulse.
- `wb_err_o` out 1: one-cycle timeout-termination pulse.
- `mem_req` out 1: memory request, held until acked.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W-1: halfword address = {`wb_adr_i`[ADDR_W-1:2], half}.
- `mem_wdata` out 16: write halfword.
- `mem_be` out 2: halfword byte enables.
- `mem_ack` in 1: one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 16: read halfword.

## Operation
- States: IDLE, LO, GAP, HI, RESP.
- IDLE
  - When `wb_cyc_i & wb_stb_i` are high, latch address, we, sel and data, and clear the read buffer to 0.
  - If `sel[1:0]` != 0, go to LO.
  - Else if `sel[3:2]` != 0, go to HI.
  - Else go to RESP with no memory access.
- LO
  - Drive `mem_req`=1, `mem_addr` = {word, 0}, `mem_be` = `sel[1:0]`, `mem_wdata` = `dat[15:0]`.
  - On `mem_ack`, capture `mem_rdata` into buffer [15:0] if a read.
  - Then go to GAP if `sel[3:2]` != 0, else go to RESP.
- GAP: exactly one cycle with `mem_req`=0, then go to HI.
- HI
  - Drive `mem_req`=1, `mem_addr` = {word, 1}, `mem_be` = `sel[3:2]`, `mem_wdata` = `dat[31:16]`.
  - On `mem_ack`, capture into buffer [31:16], then go to RESP.
- RESP
  - For one cycle, drive `wb_ack_o`=1 (or `wb_err_o`=1 if timeout is flagged) and `wb_dat_o` = buffer.
  - Return to IDLE.
- Read lanes:
  - Skipped halfwords read as 0.
  - Byte lanes within an accessed halfword are returned as delivered by memory, not masked.
- Timeout
  - A counter is cleared on entry to LO or HI and increments each cycle without `mem_ack`.
  - When it reaches TIMEOUT, drop `mem_req`, set the timeout flag and go straight to RESP, skipping any remaining halfword.
- Abort
  - If `wb_cyc_i` falls during LO, GAP or HI, finish the outstanding halfword (wait for `mem_ack` or timeout).
  - Issue no further halfwords, then return to IDLE without pulsing ack or err.
  - In GAP, return directly to IDLE.
- `wb_stb_i` still high in the IDLE cycle after RESP is a new request.
- `mem_ack` outside LO or HI is ignored.

## Timing
- Reset values: state IDLE, `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle numbering:
  - Request is sampled in IDLE at edge 0.
  - `mem_req` is high from cycle 1.
  - `mem_ack` in cycle k gives `mem_req` low in cycle k+1.
- Latency from request edge to `wb_ack_o`, with zero-wait memory (ack in the first req cycle):
  - Full 32-bit access: 4 cycles (LO, GAP, HI, RESP).
  - Single halfword: 2 cycles.
  - `sel`=0: 1 cycle.
- Each memory wait cycle adds 1 cycle per halfword.
- Timeout err fires at request edge + TIMEOUT + 1 for a single halfword.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stay stable while `mem_req` is high.
- `reset_n` asserted mid-transaction returns all outputs to reset values immediately; any pending memory access is abandoned.

## Test plan
- Write with adr=0x100, dat=0xDEADBEEF, sel=0xF, zero-wait memory:
  - Expect memory writes {addr=0x80, be=3, wdata=0xBEEF} then {0x81, 3, 0xDEAD}.
  - Expect one `mem_req`-low GAP cycle and `wb_ack_o` 4 cycles after the request.
- Read with adr=0x8, sel=0xC, memory returns 0x1234 after 3 wait cycles:
  - Expect only a halfword-1 access at `mem_addr`=0x5.
  - Expect `wb_dat_o`=0x12340000 with ack.
- Access with sel=0:
  - Expect `wb_ack_o` the cycle after the request, `mem_req` never asserted, `wb_dat_o`=0.
- TIMEOUT=4, memory never acks, sel=0xF read:
  - Expect `mem_req` high for 4 cycles then low.
  - Expect `wb_err_o` pulse, no high-half access, no `wb_ack_o`.
- `wb_cyc_i` dropped during LO of a 32-bit write:
  - Expect the low halfword to complete and no HI access.
  - Expect no ack or err, and the next request to be accepted normally.
- `reset_n` pulsed low during HI:
  - Expect all outputs 0 asynchronously and state IDLE.
  - Expect a following read to complete correctly.
